// File: rtl/nvme_sq_arb_pkg.sv
// Shared types and packed-command layout for the SQ command arbiter.
package nvme_sq_arb_pkg;

    localparam int CMD_W = 360;
    localparam int CID_W = 16;
    localparam int CNT_W = 16;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 8;
    localparam int NSID_LSB = 8;
    localparam int NSID_W   = 32;
    localparam int PRP1_LSB = 40;
    localparam int PRP1_W   = 64;
    localparam int PRP2_LSB = 104;
    localparam int PRP2_W   = 64;
    localparam int CDW_LSB  = 168;
    localparam int CDW_W    = 192;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_RELEASE   = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [OPC_W-1:0]  opc,
        input logic [NSID_W-1:0] nsid,
        input logic [PRP1_W-1:0] prp1,
        input logic [PRP2_W-1:0] prp2,
        input logic [CDW_W-1:0]  cdw
    );
        logic [CMD_W-1:0] c;
        c = '0;
        c[OPC_LSB  +: OPC_W]  = opc;
        c[NSID_LSB +: NSID_W] = nsid;
        c[PRP1_LSB +: PRP1_W] = prp1;
        c[PRP2_LSB +: PRP2_W] = prp2;
        c[CDW_LSB  +: CDW_W]  = cdw;
        return c;
    endfunction

endpackage

// File: rtl/nvme_sq_credit_cnt.sv
// Per-queue outstanding-command counter with full compare and sticky underflow.
module nvme_sq_credit_cnt
    import nvme_sq_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(DEPTH - 1);

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            // a completion with nothing in flight is dropped and flagged
            if (count == '0)
                underflow <= 1'b1;
            else
                count <= count - 1'b1;
        end
    end

    assign full = (count >= MAX_OUT);

endmodule

// File: rtl/nvme_sq_cmd_arbiter.sv
// Admin/I-O arbiter in front of the SQ command builder.
// NVME_SQ_ADMIN_STRICT_PRIO_EN: admin always wins when eligible (no round-robin).
module nvme_sq_cmd_arbiter
    import nvme_sq_arb_pkg::*;
#(
    parameter int ADM_DEPTH = 16,
    parameter int IO_DEPTH  = 64,
    parameter int CMD_W     = nvme_sq_arb_pkg::CMD_W
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             adm_req,
    input  logic [CMD_W-1:0] adm_cmd,
    output logic             adm_ack,
    input  logic             io_req,
    input  logic [CMD_W-1:0] io_cmd,
    output logic             io_ack,
    input  logic             adm_cpl,
    input  logic             io_cpl,
    output logic             write_start,
    input  logic             write_start_ack,
    output logic             is_io_queue,
    output logic [15:0]      sq_cid,
    output logic [CMD_W-1:0] sq_cmd,
    input  logic             adm_tail_done,
    input  logic             io_tail_done,
    output logic [15:0]      adm_outstanding,
    output logic [15:0]      io_outstanding,
    output logic             cpl_underflow
);

    state_t           state, state_nxt;
    logic             grant_adm, grant_io;
    logic             adm_elig, io_elig;
    logic             adm_full, io_full;
    logic             adm_uf, io_uf;
    logic [CID_W-1:0] adm_cid, io_cid;
    logic             adm_td_q, io_td_q;
    logic             sel_td_rise;

    nvme_sq_credit_cnt #(.DEPTH(ADM_DEPTH)) u_adm_cnt (
        .clk_in    (clk_in),
        .resetb    (resetb),
        .inc       (grant_adm),
        .dec       (adm_cpl),
        .count     (adm_outstanding),
        .full      (adm_full),
        .underflow (adm_uf)
    );

    nvme_sq_credit_cnt #(.DEPTH(IO_DEPTH)) u_io_cnt (
        .clk_in    (clk_in),
        .resetb    (resetb),
        .inc       (grant_io),
        .dec       (io_cpl),
        .count     (io_outstanding),
        .full      (io_full),
        .underflow (io_uf)
    );

    assign cpl_underflow = adm_uf | io_uf;
    assign adm_elig      = adm_req && !adm_full;
    assign io_elig       = io_req && !io_full;
    assign sel_td_rise   = is_io_queue ? (io_tail_done && !io_td_q)
                                       : (adm_tail_done && !adm_td_q);

`ifndef NVME_SQ_ADMIN_STRICT_PRIO_EN
    logic rr_io;

    // pointer moves to the loser only when both queues contended
    always_ff @(posedge clk_in) begin
        if (resetb)
            rr_io <= 1'b0;
        else if (grant_adm && io_elig)
            rr_io <= 1'b1;
        else if (grant_io && adm_elig)
            rr_io <= 1'b0;
    end
`endif

    always_ff @(posedge clk_in) begin
        if (resetb)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_adm   = 1'b0;
        grant_io    = 1'b0;
        write_start = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef NVME_SQ_ADMIN_STRICT_PRIO_EN
                grant_adm = adm_elig;
                grant_io  = io_elig && !adm_elig;
`else
                if (adm_elig && io_elig) begin
                    grant_io  = rr_io;
                    grant_adm = !rr_io;
                end else begin
                    grant_adm = adm_elig;
                    grant_io  = io_elig;
                end
`endif
                if (adm_elig || io_elig)
                    state_nxt = S_START;
            end
            S_START: begin
                write_start = 1'b1;
                if (write_start_ack)
                    state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!write_start_ack)
                    state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (sel_td_rise)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            adm_ack     <= 1'b0;
            io_ack      <= 1'b0;
            adm_td_q    <= 1'b0;
            io_td_q     <= 1'b0;
            is_io_queue <= 1'b0;
            sq_cid      <= '0;
            sq_cmd      <= '0;
            adm_cid     <= '0;
            io_cid      <= '0;
        end else begin
            adm_ack  <= grant_adm;
            io_ack   <= grant_io;
            adm_td_q <= adm_tail_done;
            io_td_q  <= io_tail_done;
            if (grant_adm) begin
                sq_cmd      <= adm_cmd;
                sq_cid      <= adm_cid;
                adm_cid     <= adm_cid + 1'b1;
                is_io_queue <= 1'b0;
            end else if (grant_io) begin
                sq_cmd      <= io_cmd;
                sq_cid      <= io_cid;
                io_cid      <= io_cid + 1'b1;
                is_io_queue <= 1'b1;
            end
        end
    end

endmodule
